// File: rtl/adc_acq_pkg.sv
// Shared types and defaults for the ADC acquisition sequencer.
package adc_acq_pkg;

  localparam int unsigned DATA_W_DEF    = 16;
  localparam int unsigned CNV_HIGH_DEF  = 4;
  localparam int unsigned CONV_WAIT_DEF = 8;
  localparam int unsigned CLK_DIV_DEF   = 2;
  localparam int unsigned PERIOD_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CNV_HI,
    WAIT,
    SHIFT,
    DONE
  } acq_state_t;

  function automatic int unsigned acq_len(input int unsigned cnv_high,
                                          input int unsigned conv_wait,
                                          input int unsigned clk_div,
                                          input int unsigned data_w);
    return cnv_high + conv_wait + 2 * clk_div * data_w + 1;
  endfunction

  // Cycles from the cnv rising edge to sample_valid rising with default parameters.
  localparam int unsigned ACQ_LEN = acq_len(CNV_HIGH_DEF, CONV_WAIT_DEF, CLK_DIV_DEF, DATA_W_DEF);

  // Bits needed for a counter running 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Enable-gated acquisition period counter; tick is high while the count is 0.
module adc_period_timer
  import adc_acq_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] per_q;

  assign tick = enable && (cnt == '0);

  // period is latched at the wrap so a mid-period change takes effect next period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      per_q <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      per_q <= period;
      cnt   <= (period > PERIOD_W'(1)) ? PERIOD_W'(1) : '0;
    end else if (cnt >= per_q - PERIOD_W'(1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Periodic serial SAR ADC acquisition: CNV pulse, conversion wait, adcclk burst, sample port.
// Define ADC_ACQ_TESTPAT_EN to publish an incrementing counter instead of the sdo word.
module adc_acq_sequencer
  import adc_acq_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned CNV_HIGH  = CNV_HIGH_DEF,
  parameter int unsigned CONV_WAIT = CONV_WAIT_DEF,
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
  parameter int unsigned PERIOD_W  = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                sdo,
  output logic                cnv,
  output logic                adcclk,
  output logic [DATA_W-1:0]   sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                overrun,
  output logic                period_err
);

  localparam int unsigned TW = cnt_width(max3(CNV_HIGH, CONV_WAIT, 2 * CLK_DIV));
  localparam int unsigned BW = cnt_width(DATA_W);

  localparam logic [TW-1:0] CNV_LAST  = TW'(CNV_HIGH - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(CONV_WAIT - 1);
  localparam logic [TW-1:0] PH_LAST   = TW'(2 * CLK_DIV - 1);
  localparam logic [TW-1:0] PH_RISE   = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  acq_state_t        state;
  logic [TW-1:0]     tmr;
  logic [BW-1:0]     bitcnt;
  logic              tick;

`ifdef ADC_ACQ_TESTPAT_EN
  logic [DATA_W-1:0] tp_cnt;
  logic              unused_sdo;
  assign unused_sdo = sdo;
`else
  logic [DATA_W-1:0] shreg;
`endif

  adc_period_timer #(
    .PERIOD_W(PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      tmr          <= '0;
      bitcnt       <= '0;
      cnv          <= 1'b0;
      adcclk       <= 1'b0;
      busy         <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      period_err   <= 1'b0;
`ifdef ADC_ACQ_TESTPAT_EN
      tp_cnt       <= '0;
`else
      shreg        <= '0;
`endif
    end else begin
      if (sample_valid && sample_ready)
        sample_valid <= 1'b0;
      if (tick && (state != IDLE))
        period_err <= 1'b1;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= CNV_HI;
            cnv   <= 1'b1;
            busy  <= 1'b1;
            tmr   <= '0;
          end
        end
        CNV_HI: begin
          if (tmr == CNV_LAST) begin
            state <= WAIT;
            cnv   <= 1'b0;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        WAIT: begin
          if (tmr == WAIT_LAST) begin
            state  <= SHIFT;
            tmr    <= '0;
            bitcnt <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        SHIFT: begin
          // tmr walks one adcclk period: CLK_DIV cycles low, then CLK_DIV high.
          if (tmr == PH_LAST) begin
            tmr    <= '0;
            adcclk <= 1'b0;
            if (bitcnt == BIT_LAST)
              state <= DONE;
            else
              bitcnt <= bitcnt + BW'(1);
          end else begin
            tmr <= tmr + TW'(1);
            if (tmr == PH_RISE) begin
              adcclk <= 1'b1;
`ifndef ADC_ACQ_TESTPAT_EN
              shreg  <= {shreg[DATA_W-2:0], sdo};
`endif
            end
          end
        end
        DONE: begin
`ifdef ADC_ACQ_TESTPAT_EN
          sample_data <= tp_cnt;
          tp_cnt      <= tp_cnt + DATA_W'(1);
`else
          sample_data <= shreg;
`endif
          sample_valid <= 1'b1;
          if (sample_valid && !sample_ready)
            overrun <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          cnv    <= 1'b0;
          adcclk <= 1'b0;
          busy   <= 1'b0;
        end
      endcase

      if (!enable) begin
        overrun    <= 1'b0;
        period_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Scoreboard bench for adc_acq_sequencer with default parameters (ACQ_LEN = 77).
`timescale 1ns/1ps
module tb_adc_acq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic        sdo = 1'b0;
  logic        cnv;
  logic        adcclk;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic        overrun;
  logic        period_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int cnv_rises = 0;
  int cnv_rise_cyc = 0;
  int cnv_hi_len = 0;
  int adc_hi_cnt = 0;
  int first_adc_rise = -1;
  int valid_rise_cyc = 0;
  int loads = 0;
  bit prev_busy, prev_cnv, prev_adc, prev_valid;

  logic [15:0] sb[$];
  logic [15:0] exp_word;
  logic [15:0] cur_word = 16'h0000;
  logic [15:0] word_sh = 16'h0000;
  logic [15:0] tp_next = 16'h0000;
  int          bitidx = -1;
  bit          force_sdo0 = 1'b0;

  adc_acq_sequencer #(
    .DATA_W    (16),
    .CNV_HIGH  (4),
    .CONV_WAIT (8),
    .CLK_DIV   (2),
    .PERIOD_W  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .period       (period),
    .sdo          (sdo),
    .cnv          (cnv),
    .adcclk       (adcclk),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun),
    .period_err   (period_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC model: MSB ready at cnv rise, next bit presented on each adcclk fall.
  always @(posedge cnv or negedge adcclk) begin
    if (cnv) begin
      word_sh = cur_word;
      bitidx  = 15;
    end else begin
      bitidx--;
    end
    sdo = (force_sdo0 || bitidx < 0) ? 1'b0 : word_sh[bitidx];
  end

  task automatic monitor();
    if (!reset) begin
      prev_busy  = 1'b0;
      prev_cnv   = 1'b0;
      prev_adc   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (cnv && !prev_cnv) begin
        cnv_rises++;
        cnv_rise_cyc   = cyc;
        cnv_hi_len     = 0;
        adc_hi_cnt     = 0;
        first_adc_rise = -1;
`ifdef ADC_ACQ_TESTPAT_EN
        sb.push_back(tp_next);
        tp_next = tp_next + 16'd1;
`else
        sb.push_back(word_sh);
`endif
      end
      if (cnv) cnv_hi_len++;
      if (adcclk && !prev_adc && first_adc_rise < 0) first_adc_rise = cyc;
      if (adcclk) adc_hi_cnt++;
      if (sample_valid && !prev_valid) valid_rise_cyc = cyc;
      if (prev_busy && !busy) begin
        loads++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: sample %h loaded, no expected entry", sample_data);
        end else begin
          exp_word = sb.pop_front();
          if (sample_data !== exp_word || sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL sample_data: got %h valid=%b, expected %h valid=1",
                     sample_data, sample_valid, exp_word);
          end
        end
      end
      prev_busy  = busy;
      prev_cnv   = cnv;
      prev_adc   = adcclk;
      prev_valid = sample_valid;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      #1;
    end
  endtask

  task automatic wait_cnv(input int limit, output bit ok);
    int start;
    start = cnv_rises;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (cnv_rises != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_load(input int limit, output bit ok);
    int start;
    start = loads;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (loads != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    int r0;
    step(3);
    checks++;
    if ({cnv, adcclk, busy, sample_valid, overrun, period_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {cnv, adcclk, busy, sample_valid, overrun, period_err});
    end
    checks++;
    if (sample_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0000", sample_data);
    end
    reset = 1'b1;
    step(20);
    checks++;
    if (cnv_rises !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_enable: cnv_rises=%0d busy=%b, expected 0 0", cnv_rises, busy);
    end
    sample_ready = 1'b0;
    period = 16'd100;
    cur_word = 16'h1234;
    enable = 1'b1;
    wait_load(120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_pre_load: timeout, expected a sample"); end
    wait_cnv(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_pre_cnv: timeout, expected second cnv"); end
    for (int i = 0; i < 30 && adcclk !== 1'b1; i++) step(1);
    checks++;
    if ({busy, sample_valid, adcclk} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_state: busy,valid,adcclk=%b, expected 111", {busy, sample_valid, adcclk});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({cnv, adcclk, busy, sample_valid} !== 4'b0) begin
      errors++;
      $display("FAIL async_reset: cnv,adcclk,busy,valid=%b, expected 0000",
               {cnv, adcclk, busy, sample_valid});
    end
    sb.delete();
    tp_next = 16'h0000;
    enable = 1'b0;
    step(2);
    reset = 1'b1;
    r0 = cnv_rises;
    step(30);
    checks++;
    if (cnv_rises !== r0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: new cnv=%0d busy=%b valid=%b, expected 0 0 0",
               cnv_rises - r0, busy, sample_valid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int c0;
    sample_ready = 1'b1;
    period = 16'd100;
    cur_word = 16'hA5C3;
    enable = 1'b1;
    wait_cnv(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_cnv: timeout, expected cnv rise"); end
    c0 = cnv_rise_cyc;
    cur_word = 16'h3C5A;
    wait_load(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_load: timeout, expected sample"); end
    checks++;
    if (cnv_hi_len !== 4) begin
      errors++; $display("FAIL cnv_high: got %0d cycles, expected 4", cnv_hi_len);
    end
    checks++;
    if (first_adc_rise - c0 !== 14) begin
      errors++; $display("FAIL adcclk_first_rise: got %0d, expected 14", first_adc_rise - c0);
    end
    checks++;
    if (adc_hi_cnt !== 32) begin
      errors++; $display("FAIL adcclk_high_cycles: got %0d, expected 32", adc_hi_cnt);
    end
    checks++;
    if (valid_rise_cyc - c0 !== 77) begin
      errors++; $display("FAIL latency: got %0d, expected 77", valid_rise_cyc - c0);
    end
    step(1);
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL handshake_clear: valid=%b, expected 0", sample_valid);
    end
    wait_cnv(40, ok);
    checks++;
    if (!ok || cnv_rise_cyc - c0 !== 100) begin
      errors++; $display("FAIL period_100: got %0d (ok=%b), expected 100", cnv_rise_cyc - c0, ok);
    end
    wait_load(100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_load2: timeout, expected sample"); end
    enable = 1'b0;
    step(2);
  endtask

  task automatic test_backpressure();
    bit ok;
    sample_ready = 1'b0;
    period = 16'd100;
    cur_word = 16'hBEEF;
    enable = 1'b1;
    wait_cnv(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_cnv: timeout, expected cnv rise"); end
    cur_word = 16'hCAFE;
    wait_load(100, ok);
    checks++;
    if (!ok || sample_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: ok=%b valid=%b overrun=%b, expected 1 1 0", ok, sample_valid, overrun);
    end
    wait_load(120, ok);
    checks++;
    if (!ok || sample_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_overwrite: ok=%b valid=%b overrun=%b, expected 1 1 1", ok, sample_valid, overrun);
    end
    sample_ready = 1'b1;
    step(1);
    sample_ready = 1'b0;
    checks++;
    if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_single_handshake: valid=%b overrun=%b, expected 0 1", sample_valid, overrun);
    end
    enable = 1'b0;
    step(1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL bp_overrun_clear: overrun=%b, expected 0", overrun);
    end
    step(2);
  endtask

  task automatic test_short_period();
    bit ok;
    int c0;
    sample_ready = 1'b1;
    period = 16'd50;
    cur_word = 16'h0F0F;
    enable = 1'b1;
    wait_cnv(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sp_cnv: timeout, expected cnv rise"); end
    c0 = cnv_rise_cyc;
    cur_word = 16'hF00F;
    step(40);
    checks++;
    if (period_err !== 1'b0) begin
      errors++; $display("FAIL sp_err_early: period_err=%b, expected 0", period_err);
    end
    step(15);
    checks++;
    if (period_err !== 1'b1) begin
      errors++; $display("FAIL sp_err_set: period_err=%b, expected 1", period_err);
    end
    wait_cnv(60, ok);
    checks++;
    if (!ok || cnv_rise_cyc - c0 !== 100) begin
      errors++; $display("FAIL sp_spacing: got %0d (ok=%b), expected 100", cnv_rise_cyc - c0, ok);
    end
  endtask

  task automatic test_disable_mid();
    bit ok;
    int c1;
    int r0;
    c1 = cnv_rise_cyc;
    r0 = cnv_rises;
    step(6);
    enable = 1'b0;
    step(1);
    checks++;
    if (period_err !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL dis_flags_clear: period_err=%b overrun=%b, expected 0 0", period_err, overrun);
    end
    wait_load(100, ok);
    checks++;
    if (!ok || valid_rise_cyc - c1 !== 77) begin
      errors++; $display("FAIL dis_completes: latency %0d (ok=%b), expected 77", valid_rise_cyc - c1, ok);
    end
    step(150);
    checks++;
    if (cnv_rises !== r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dis_no_restart: new cnv=%0d busy=%b, expected 0 0", cnv_rises - r0, busy);
    end
  endtask

`ifdef ADC_ACQ_TESTPAT_EN
  task automatic test_testpat();
    bit ok;
    reset = 1'b0;
    #1;
    sb.delete();
    tp_next = 16'h0000;
    step(2);
    reset = 1'b1;
    force_sdo0 = 1'b1;
    sample_ready = 1'b1;
    period = 16'd100;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_load(120, ok);
      checks++;
      if (!ok || sample_data !== 16'(i)) begin
        errors++; $display("FAIL testpat_%0d: got %h (ok=%b), expected %h", i, sample_data, ok, 16'(i));
      end
    end
    enable = 1'b0;
    step(2);
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    period       = 16'd0;
    sample_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_short_period();
    test_disable_mid();
`ifdef ADC_ACQ_TESTPAT_EN
    test_testpat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
